pcie_tlp_mwr_initiator: RTL

PCIE_TLP_MWR_INITIATOR -- requirements
Module: pcie_tlp_mwr_initiator

---
 rtl/pcie_tlp_pkg.sv | 54 +++++
 rtl/tlp_req_fifo.sv | 51 +++++
 rtl/pcie_tlp_mwr_initiator.sv | 114 +++++++++++
 3 files changed

// File: rtl/pcie_tlp_pkg.sv
// Shared PCIe TLP constants, FSM state type and the MWr beat builder used by
// the posted-write initiator.
package pcie_tlp_pkg;

   localparam logic [2:0] FMT_3DW_DATA = 3'b010;
   localparam logic [2:0] FMT_4DW_DATA = 3'b011;
   localparam logic [4:0] TYPE_MEM     = 5'b00000;

   // Posted credit fields inside tl_tx_p_credits
   localparam int unsigned PH_LSB = 0;
   localparam int unsigned PH_W   = 8;
   localparam int unsigned PD_LSB = 8;
   localparam int unsigned PD_W   = 12;

   localparam int unsigned REQ_W = 100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARB,
      ST_SEND
   } tx_state_t;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } mwr_req_t;

   typedef struct packed {
      logic [255:0] data;
      logic [7:0]   valid;
   } tx_beat_t;

   // Single-DW memory write: 3DW header below 4 GiB, 4DW header above.
   function automatic tx_beat_t build_mwr(input mwr_req_t req, input logic [12:0] busdev);
      tx_beat_t    beat;
      logic [31:0] dw0;
      logic [31:0] dw1;
      logic        is_4dw;
      beat   = '0;
      is_4dw = (req.addr[63:32] != '0);
      dw0    = {(is_4dw ? FMT_4DW_DATA : FMT_3DW_DATA), TYPE_MEM, 14'd0, 10'd1};
      dw1    = {busdev, 3'b000, 8'h00, 4'b0000, req.be};
      if (is_4dw) begin
         beat.data[159:0] = {req.data, req.addr[31:2], 2'b00, req.addr[63:32], dw1, dw0};
         beat.valid       = 8'h1F;
      end else begin
         beat.data[127:0] = {req.data, req.addr[31:2], 2'b00, dw1, dw0};
         beat.valid       = 8'h0F;
      end
      return beat;
   endfunction

endpackage

// File: rtl/tlp_req_fifo.sv
// Synchronous request queue with full/empty flags; read data is the current
// head entry, valid whenever empty is low.
module tlp_req_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pcie_tlp_mwr_initiator.sv
// Queues single-DW posted write requests and emits each as one MWr TLP beat
// once the TX port is granted and posted credits are available.
module pcie_tlp_mwr_initiator
   import pcie_tlp_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [63:0]  req_addr,
   input  logic [31:0]  req_data,
   input  logic [3:0]   req_be,
   input  logic [12:0]  tl_cfg_busdev,
   input  logic [31:0]  tl_tx_p_credits,
   output logic         tx_req,
   input  logic         tx_gnt,
   input  logic         tl_tx_wait,
   output logic         tl_tx_sop,
   output logic         tl_tx_eop,
   output logic [255:0] tl_tx_data,
   output logic [7:0]   tl_tx_valid,
   output logic         busy,
   output logic [15:0]  sent_cnt
);

   tx_state_t state_q;
   tx_state_t state_d;
   mwr_req_t  push_word;
   mwr_req_t  head;
   tx_beat_t  beat_d;
   logic      fifo_full;
   logic      fifo_empty;
   logic      pop;
   logic      credits_ok;
   logic      tx_req_d;
   logic      sop_d;
   logic      credits_unused;

   assign push_word      = '{addr: req_addr, data: req_data, be: req_be};
   assign req_ready      = !fifo_full;
   assign credits_ok     = (tl_tx_p_credits[PH_LSB +: PH_W] != '0) &&
                           (tl_tx_p_credits[PD_LSB +: PD_W] != '0);
   assign credits_unused = ^tl_tx_p_credits[31:PD_LSB+PD_W];
   assign busy           = !fifo_empty || (state_q != ST_IDLE);

   tlp_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REQ_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (req_valid),
      .pop     (pop),
      .wr_data (push_word),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (!fifo_empty)            state_d = ST_ARB;
         ST_ARB:  if (tx_gnt && credits_ok)   state_d = ST_SEND;
         ST_SEND: if (!tl_tx_wait)            state_d = ST_IDLE;
         default:                             state_d = ST_IDLE;
      endcase
   end

   // Next values for the TX registers: load on ARB->SEND, hold while stalled.
   always_comb begin
      tx_req_d = (state_d != ST_IDLE);
      beat_d   = '0;
      sop_d    = 1'b0;
      pop      = 1'b0;
      if (state_q == ST_SEND) begin
         if (tl_tx_wait) begin
            beat_d = '{data: tl_tx_data, valid: tl_tx_valid};
            sop_d  = tl_tx_sop;
         end else begin
            pop = 1'b1;
         end
      end else if (state_d == ST_SEND) begin
         beat_d = build_mwr(head, tl_cfg_busdev);
         sop_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_req      <= 1'b0;
         tl_tx_sop   <= 1'b0;
         tl_tx_eop   <= 1'b0;
         tl_tx_data  <= '0;
         tl_tx_valid <= '0;
         sent_cnt    <= '0;
      end else begin
         tx_req      <= tx_req_d;
         tl_tx_sop   <= sop_d;
         tl_tx_eop   <= sop_d;
         tl_tx_data  <= beat_d.data;
         tl_tx_valid <= beat_d.valid;
         if (pop) sent_cnt <= sent_cnt + 16'd1;
      end
   end

endmodule
